// File: rtl/surf4_led_spi_pkg.sv
// -----------------------------------------------------------------------------
// surf4_led_spi_pkg
//   Shared definitions for the SURF4 LED SPI serialiser.
//   - SURF4_LED_HDR : frame header nibble. surf4_id_ctrl and the iCE40 LED
//                     firmware decode frames against this same value.
//   - Frame geometry (LED width, frame width, SCK half-periods, GAP length).
//   - led_spi_state_e : serialiser FSM states.
//   - frame_word()    : assembles one {header, led} frame word, MSB first.
// -----------------------------------------------------------------------------
package surf4_led_spi_pkg;

  localparam logic [3:0] SURF4_LED_HDR = 4'hA;

  localparam int LED_W       = 12;
  localparam int FRAME_W     = 16;
  // Two SCK half-periods per bit.
  localparam int SHIFT_TICKS = 2 * FRAME_W;
  // CS_B-high ticks between the end of one frame and done_o.
  localparam int GAP_TICKS   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } led_spi_state_e;

  function automatic logic [FRAME_W-1:0] frame_word(
    input logic [3:0]       hdr,
    input logic [LED_W-1:0] led
  );
    return {hdr, led};
  endfunction

endpackage

// File: rtl/surf4_led_spi.sv
// -----------------------------------------------------------------------------
// surf4_led_spi
//   Serialises the LED state coming from surf4_id_ctrl into 16-bit SPI
//   frames ({HDR, led[11:0]}, MSB first, SPI mode 0) for the iCE40 LED
//   controller, and captures the word shifted back on MISO.
//   A frame is sent after reset, whenever led_i differs from what was last
//   sent, on update_i, and on a periodic refresh.
//
// Ports
//   clk_i     in   1   system clock
//   rst_i     in   1   asynchronous reset, active-high
//   led_i     in   12  requested LED state
//   update_i  in   1   single-cycle strobe: force a frame
//   busy_o    out  1   frame in progress (SETUP entry through done_o cycle)
//   done_o    out  1   one-cycle pulse when a frame completes
//   rdata_o   out  16  last MISO word captured, MSB first
//   SCK       out  1   SPI clock, mode 0
//   MOSI      out  1   SPI data out
//   CS_B      out  1   SPI chip select, active-low
//   MISO      in   1   SPI data in
//
// Timing: one tick = CLK_DIV clk_i cycles. SETUP 1 tick, SHIFT 32 ticks,
// HOLD 1 tick, GAP 2 ticks, so done_o rises 36*CLK_DIV cycles after SETUP
// entry. All SPI pins come straight from flops.
// -----------------------------------------------------------------------------
module surf4_led_spi
  import surf4_led_spi_pkg::*;
#(
  parameter int         CLK_DIV        = 8,
  parameter int         REFRESH_CYCLES = 33333333,
  parameter logic [3:0] HDR            = SURF4_LED_HDR
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [LED_W-1:0]   led_i,
  input  logic               update_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [FRAME_W-1:0] rdata_o,
  output logic               SCK,
  output logic               MOSI,
  output logic               CS_B,
  input  logic               MISO
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int              DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD    = DIV_W'(CLK_DIV - 1);

  localparam bit              REFRESH_ON   = (REFRESH_CYCLES > 0);
  localparam int              REF_W        = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [REF_W-1:0] REFRESH_LAST = REF_W'((REFRESH_CYCLES > 0) ? (REFRESH_CYCLES - 1) : 0);

  localparam logic [4:0]      LAST_HALF    = 5'(SHIFT_TICKS - 1);
  // Half-period after which the final data bit is on the wire; MOSI is not
  // advanced past it.
  localparam logic [4:0]      LAST_BIT_HI  = 5'(SHIFT_TICKS - 2);
  localparam logic [4:0]      LAST_GAP     = 5'(GAP_TICKS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  led_spi_state_e     state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [4:0]         bit_q, bit_d;          // half-period / gap tick index
  logic               pending_q, pending_d;
  logic [LED_W-1:0]   led_snap_q, led_snap_d;
  logic [LED_W-1:0]   last_sent_q, last_sent_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [FRAME_W-1:0] rdata_q, rdata_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               csb_q, csb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [REF_W-1:0]   refresh_q, refresh_d;

  // ---------------------------------------------------------------------------
  // Event qualification
  // ---------------------------------------------------------------------------
  logic               tick;
  logic               refresh_hit;
  logic               start;
  logic               absorb;
  logic               request;
  logic               led_changed;
  logic [LED_W-1:0]   led_ref;

  // The divider only runs inside a frame and is reloaded on SETUP entry, so
  // every state lasts exactly CLK_DIV cycles per tick.
  assign tick = (div_q == '0);

  // Free-running refresh counter; it keeps counting through frames.
  always_comb begin
    refresh_d   = refresh_q;
    refresh_hit = 1'b0;
    if (REFRESH_ON) begin
      if (refresh_q == REFRESH_LAST) begin
        refresh_d   = '0;
        refresh_hit = 1'b1;
      end else begin
        refresh_d = refresh_q + 1'b1;
      end
    end
  end

  assign start   = (state_q == ST_IDLE) && pending_q;
  // While SETUP is running (or about to be entered) no LED bit has left yet,
  // so an explicit request is served by this frame: the snapshot is refreshed
  // instead of queuing a second, identical frame.
  assign absorb  = start || (state_q == ST_SETUP);
  assign request = update_i || refresh_hit;

  // In IDLE compare against what the controller holds; during a frame compare
  // against what is being sent, otherwise the frame that carries a change
  // would itself look like a pending change until its HOLD completes.
  assign led_ref     = (state_q == ST_IDLE) ? last_sent_q : led_snap_q;
  assign led_changed = (led_i != led_ref);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    led_snap_d  = led_snap_q;
    last_sent_d = last_sent_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    csb_d       = csb_q;
    done_d      = 1'b0;

    // Divider
    if (state_q == ST_IDLE) begin
      div_d = DIV_LOAD;
    end else if (tick) begin
      div_d = DIV_LOAD;
    end else begin
      div_d = div_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        csb_d = 1'b1;
        sck_d = 1'b0;
        if (pending_q) begin
          state_d    = ST_SETUP;
          csb_d      = 1'b0;
          bit_d      = '0;
          led_snap_d = led_i;
          mosi_d     = HDR[3];     // frame bit 15 is the header MSB
        end
      end

      ST_SETUP: begin
        if (request) begin
          led_snap_d = led_i;
        end
        if (tick) begin
          state_d = ST_SHIFT;
          bit_d   = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[FRAME_W-2:0], MISO};
          tx_d    = frame_word(HDR, led_snap_d);
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (bit_q == LAST_HALF) begin
            state_d = ST_HOLD;
            sck_d   = 1'b0;
          end else begin
            bit_d = bit_q + 5'd1;
            if (!bit_q[0]) begin
              // End of a high half-period: falling edge, present next bit.
              sck_d = 1'b0;
              if (bit_q != LAST_BIT_HI) begin
                tx_d   = tx_q << 1;
                mosi_d = tx_d[FRAME_W-1];
              end
            end else begin
              // End of a low half-period: rising edge, sample MISO.
              sck_d = 1'b1;
              rx_d  = {rx_q[FRAME_W-2:0], MISO};
            end
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          state_d     = ST_GAP;
          csb_d       = 1'b1;
          mosi_d      = 1'b0;
          bit_d       = '0;
          rdata_d     = rx_q;
          last_sent_d = led_snap_q;
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (bit_q == LAST_GAP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        csb_d   = 1'b1;
        sck_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // Pending request flag: cleared when a frame starts (that frame serves
  // anything arriving in the same cycle), set by any later event.
  always_comb begin
    pending_d = pending_q;
    if (start) begin
      pending_d = 1'b0;
    end else if ((request && !absorb) || (led_changed && !(absorb && request))) begin
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      div_q       <= DIV_LOAD;
      bit_q       <= '0;
      pending_q   <= 1'b1;     // guarantees one frame after reset release
      led_snap_q  <= '0;
      last_sent_q <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      csb_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      refresh_q   <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      pending_q   <= pending_d;
      led_snap_q  <= led_snap_d;
      last_sent_q <= last_sent_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      csb_q       <= csb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      refresh_q   <= refresh_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign SCK     = sck_q;
  assign MOSI    = mosi_q;
  assign CS_B    = csb_q;

endmodule
